// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter.
// Sends one command byte to a PS/2 device: inhibits the bus, issues a
// request-to-send, shifts out 8 data bits + odd parity + stop on the device
// clock, samples the device ACK, then waits for the bus to return idle.
// Both bus lines are open-drain: the block only ever pulls them low or
// releases them.
module ps2_host_tx #(
    parameter int INHIBIT_CYC  = 5000,
    parameter int START_TO_CYC = 750000,
    parameter int XFER_TO_CYC  = 100000
) (
    input  logic       CLOCK_50,
    input  logic       rstN,
    input  logic       send,
    input  logic [7:0] cmd,
    inout  wire        PS2_CLK,
    inout  wire        PS2_DAT,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       err_type
);

    localparam int INH_W = $clog2(INHIBIT_CYC + 1);
    localparam int STA_W = $clog2(START_TO_CYC + 1);
    localparam int XFR_W = $clog2(XFER_TO_CYC + 1);

    // Terminal counts: each counter stops here, so none of them can wrap.
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYC - 1);
    localparam logic [STA_W-1:0] STA_LAST = STA_W'(START_TO_CYC - 1);
    localparam logic [XFR_W-1:0] XFR_LAST = XFR_W'(XFER_TO_CYC - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        INHIBIT  = 3'd1,
        RTS      = 3'd2,
        BITS     = 3'd3,
        ACK      = 3'd4,
        WAITIDLE = 3'd5
    } state_t;

    state_t             state_r, state_n;
    logic [8:0]         shift_r, shift_n;       // {parity, cmd}, LSB goes out first
    logic [3:0]         bit_cnt_r, bit_cnt_n;   // falling edges seen so far
    logic [INH_W-1:0]   inh_cnt_r, inh_cnt_n;
    logic [STA_W-1:0]   start_cnt_r, start_cnt_n;
    logic [XFR_W-1:0]   xfer_cnt_r, xfer_cnt_n;
    logic               nack_r, nack_n;
    logic               clk_oe_r, clk_oe_n;     // 1 = pull PS2_CLK low
    logic               dat_oe_r, dat_oe_n;     // 1 = pull PS2_DAT low
    logic               busy_r, busy_n;
    logic               done_r, done_n;
    logic               err_r, err_n;
    logic               err_type_r, err_type_n;

    logic               clk_s1_r, clk_s2_r, clk_s3_r;
    logic               dat_s1_r, dat_s2_r;
    logic               clk_fall;
    logic               xfer_exp;

    // Open-drain line drivers: only ever 0 or released.
    assign PS2_CLK = clk_oe_r ? 1'b0 : 1'bz;
    assign PS2_DAT = dat_oe_r ? 1'b0 : 1'bz;

    assign busy     = busy_r;
    assign done     = done_r;
    assign err      = err_r;
    assign err_type = err_type_r;

    // Falling edge of the synchronised device clock, one cycle after the second flop.
    assign clk_fall = clk_s3_r & ~clk_s2_r;
    assign xfer_exp = (xfer_cnt_r == XFR_LAST);

    // Two-flop synchronisers for both bus lines plus an edge-detect delay stage.
    always_ff @(posedge CLOCK_50 or negedge rstN) begin
        if (!rstN) begin
            clk_s1_r <= 1'b0;
            clk_s2_r <= 1'b0;
            clk_s3_r <= 1'b0;
            dat_s1_r <= 1'b0;
            dat_s2_r <= 1'b0;
        end else begin
            clk_s1_r <= PS2_CLK;
            clk_s2_r <= clk_s1_r;
            clk_s3_r <= clk_s2_r;
            dat_s1_r <= PS2_DAT;
            dat_s2_r <= dat_s1_r;
        end
    end

    // State, datapath and registered outputs; async reset releases both lines at once.
    always_ff @(posedge CLOCK_50 or negedge rstN) begin
        if (!rstN) begin
            state_r     <= IDLE;
            shift_r     <= 9'd0;
            bit_cnt_r   <= 4'd0;
            inh_cnt_r   <= '0;
            start_cnt_r <= '0;
            xfer_cnt_r  <= '0;
            nack_r      <= 1'b0;
            clk_oe_r    <= 1'b0;
            dat_oe_r    <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            err_type_r  <= 1'b0;
        end else begin
            state_r     <= state_n;
            shift_r     <= shift_n;
            bit_cnt_r   <= bit_cnt_n;
            inh_cnt_r   <= inh_cnt_n;
            start_cnt_r <= start_cnt_n;
            xfer_cnt_r  <= xfer_cnt_n;
            nack_r      <= nack_n;
            clk_oe_r    <= clk_oe_n;
            dat_oe_r    <= dat_oe_n;
            busy_r      <= busy_n;
            done_r      <= done_n;
            err_r       <= err_n;
            err_type_r  <= err_type_n;
        end
    end

    // Next-state logic, counters and next values of the registered outputs.
    always_comb begin
        state_n     = state_r;
        shift_n     = shift_r;
        bit_cnt_n   = bit_cnt_r;
        inh_cnt_n   = inh_cnt_r;
        start_cnt_n = start_cnt_r;
        xfer_cnt_n  = xfer_cnt_r;
        nack_n      = nack_r;
        clk_oe_n    = clk_oe_r;
        dat_oe_n    = dat_oe_r;
        done_n      = 1'b0;
        err_n       = 1'b0;
        err_type_n  = err_type_r;

        case (state_r)
            IDLE: begin
                clk_oe_n = 1'b0;
                dat_oe_n = 1'b0;
                // A send coinciding with the done/err pulse is still part of
                // the finished transfer and is dropped.
                if (send && !done_r && !err_r) begin
                    shift_n     = {~^cmd, cmd};
                    bit_cnt_n   = 4'd0;
                    inh_cnt_n   = '0;
                    start_cnt_n = '0;
                    xfer_cnt_n  = '0;
                    nack_n      = 1'b0;
                    clk_oe_n    = 1'b1;
                    dat_oe_n    = (INHIBIT_CYC == 1);
                    state_n     = INHIBIT;
                end else begin
                    state_n = IDLE;
                end
            end

            INHIBIT: begin
                if (inh_cnt_r == INH_LAST) begin
                    clk_oe_n    = 1'b0;
                    dat_oe_n    = 1'b1;
                    start_cnt_n = '0;
                    state_n     = RTS;
                end else begin
                    inh_cnt_n = inh_cnt_r + 1'b1;
                    // Data goes low in the final inhibit cycle.
                    dat_oe_n  = (inh_cnt_n == INH_LAST);
                end
            end

            RTS: begin
                if (clk_fall) begin
                    dat_oe_n   = ~shift_r[0];
                    shift_n    = {1'b1, shift_r[8:1]};
                    bit_cnt_n  = 4'd1;
                    xfer_cnt_n = '0;
                    state_n    = BITS;
                end else if (start_cnt_r == STA_LAST) begin
                    clk_oe_n   = 1'b0;
                    dat_oe_n   = 1'b0;
                    err_n      = 1'b1;
                    err_type_n = 1'b1;
                    state_n    = IDLE;
                end else begin
                    start_cnt_n = start_cnt_r + 1'b1;
                end
            end

            BITS: begin
                if (xfer_exp) begin
                    clk_oe_n   = 1'b0;
                    dat_oe_n   = 1'b0;
                    err_n      = 1'b1;
                    err_type_n = 1'b1;
                    state_n    = IDLE;
                end else begin
                    xfer_cnt_n = xfer_cnt_r + 1'b1;
                    if (clk_fall) begin
                        bit_cnt_n = bit_cnt_r + 4'd1;
                        if (bit_cnt_r == 4'd9) begin
                            // 10th edge: release data so the stop bit reads 1.
                            dat_oe_n = 1'b0;
                            state_n  = ACK;
                        end else begin
                            dat_oe_n = ~shift_r[0];
                            shift_n  = {1'b1, shift_r[8:1]};
                        end
                    end else begin
                        bit_cnt_n = bit_cnt_r;
                    end
                end
            end

            ACK: begin
                if (xfer_exp) begin
                    clk_oe_n   = 1'b0;
                    dat_oe_n   = 1'b0;
                    err_n      = 1'b1;
                    err_type_n = 1'b1;
                    state_n    = IDLE;
                end else begin
                    xfer_cnt_n = xfer_cnt_r + 1'b1;
                    if (clk_fall) begin
                        nack_n  = dat_s2_r;
                        state_n = WAITIDLE;
                    end else begin
                        state_n = ACK;
                    end
                end
            end

            WAITIDLE: begin
                if (clk_s2_r && dat_s2_r) begin
                    done_n     = ~nack_r;
                    err_n      = nack_r;
                    err_type_n = nack_r ? 1'b0 : err_type_r;
                    state_n    = IDLE;
                end else if (xfer_exp) begin
                    clk_oe_n   = 1'b0;
                    dat_oe_n   = 1'b0;
                    err_n      = 1'b1;
                    err_type_n = 1'b1;
                    state_n    = IDLE;
                end else begin
                    xfer_cnt_n = xfer_cnt_r + 1'b1;
                end
            end

            default: begin
                clk_oe_n = 1'b0;
                dat_oe_n = 1'b0;
                state_n  = IDLE;
            end
        endcase

        busy_n = (state_n != IDLE);
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a PS/2 device model clocks transfers from a
// vector table, plus hand-written start-timeout and mid-transfer reset cases.
module tb_ps2_host_tx;

    localparam int INH  = 5000;
    localparam int STO  = 400;
    localparam int XTO  = 1500;
    localparam int HALF = 20;

    typedef struct {
        logic [7:0] cmd;
        logic       nack;
        logic       spam;
        logic [9:0] bits;     // expected DAT at device edges 1..10 (bit 0 = edge 1)
        logic       exp_done;
        logic       exp_err;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       send;
    logic [7:0] cmd;
    logic       busy, done, err, err_type;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;
    wire        ps2_clk;
    wire        ps2_dat;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;

    vec_t vecs [5];
    vec_t v_f5;

    pullup (ps2_clk);
    pullup (ps2_dat);
    assign ps2_clk = dev_clk_low ? 1'b0 : 1'bz;
    assign ps2_dat = dev_dat_low ? 1'b0 : 1'bz;

    ps2_host_tx #(
        .INHIBIT_CYC  (INH),
        .START_TO_CYC (STO),
        .XFER_TO_CYC  (XTO)
    ) dut (
        .CLOCK_50 (clk),
        .rstN     (rst_n),
        .send     (send),
        .cmd      (cmd),
        .PS2_CLK  (ps2_clk),
        .PS2_DAT  (ps2_dat),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .err_type (err_type)
    );

    always #10 clk = ~clk;

    // Count every done/err pulse seen over the whole run.
    always @(negedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
        if (err)  err_cnt  <= err_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pulse_send(input logic [7:0] c);
        @(negedge clk);
        send = 1'b1;
        cmd  = c;
        @(negedge clk);
        send = 1'b0;
    endtask

    // Count cycles PS2_CLK stays low and the cycle index where DAT first goes low.
    task automatic wait_inhibit(output int low_cnt, output int dat_idx);
        low_cnt = 0;
        dat_idx = -1;
        while (ps2_clk == 1'b0 && low_cnt < INH + 1000) begin
            if (ps2_dat == 1'b0 && dat_idx < 0) dat_idx = low_cnt;
            low_cnt++;
            @(negedge clk);
        end
    endtask

    // One device clock pulse; the device reads DAT just before releasing CLK.
    task automatic dev_edge(input int e, input logic ack, input logic spam, output logic smp);
        if (e == 11 && ack) begin
            dev_dat_low = 1'b1;
            repeat (3) @(negedge clk);
        end
        dev_clk_low = 1'b1;
        if (spam) begin
            repeat (HALF / 2) @(negedge clk);
            send = 1'b1;
            cmd  = 8'h55;
            @(negedge clk);
            send = 1'b0;
            repeat (HALF / 2 - 1) @(negedge clk);
        end else begin
            repeat (HALF) @(negedge clk);
        end
        smp = ps2_dat;
        dev_clk_low = 1'b0;
        if (e == 11) dev_dat_low = 1'b0;
        else repeat (HALF) @(negedge clk);
    endtask

    task automatic run_vec(input vec_t v, input logic sent);
        int low_cnt, dat_idx, t, d0, e0;
        logic [9:0] got;
        logic smp;
        d0 = done_cnt;
        e0 = err_cnt;
        got = 10'd0;
        if (!sent) pulse_send(v.cmd);
        wait_inhibit(low_cnt, dat_idx);
        check("inhibit_len", 32'(low_cnt), 32'(INH));
        check("inhibit_dat_idx", 32'(dat_idx), 32'(INH - 1));
        check("rts_start_bit", 32'(ps2_dat), 32'd0);
        repeat (30) @(negedge clk);
        for (int e = 1; e <= 11; e++) begin
            dev_edge(e, !v.nack, v.spam, smp);
            if (e <= 10) got[e-1] = smp;
        end
        t = 0;
        while (!(done || err) && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("end_pulse_seen", 32'(t < 200), 32'd1);
        check("done", 32'(done), 32'(v.exp_done));
        check("err", 32'(err), 32'(v.exp_err));
        if (v.exp_err) check("err_type_nack", 32'(err_type), 32'd0);
        check("busy_falls", 32'(busy), 32'd0);
        // send during the completion pulse must be dropped
        send = 1'b1;
        cmd  = 8'h55;
        @(negedge clk);
        send = 1'b0;
        check("pulse_one_cycle", 32'({done, err}), 32'd0);
        @(negedge clk);
        check("send_in_pulse_ignored", 32'(busy), 32'd0);
        check("bits", 32'(got), 32'(v.bits));
        check("done_count", 32'(done_cnt - d0), 32'(v.exp_done));
        check("err_count", 32'(err_cnt - e0), 32'(v.exp_err));
    endtask

    initial begin
        int low_cnt, dat_idx, t, d0, e0;
        logic smp;

        // cmd, nack, spam, {stop, parity, cmd}, done, err
        vecs[0] = '{8'hF4, 1'b0, 1'b0, 10'h2F4, 1'b1, 1'b0};
        vecs[1] = '{8'h00, 1'b0, 1'b0, 10'h300, 1'b1, 1'b0};
        vecs[2] = '{8'hFF, 1'b0, 1'b0, 10'h3FF, 1'b1, 1'b0};
        vecs[3] = '{8'hAA, 1'b1, 1'b1, 10'h3AA, 1'b0, 1'b1};
        vecs[4] = '{8'h01, 1'b0, 1'b1, 10'h201, 1'b1, 1'b0};
        v_f5    = '{8'hF5, 1'b0, 1'b0, 10'h3F5, 1'b1, 1'b0};

        rst_n = 1'b0;
        send  = 1'b0;
        cmd   = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_err_type", 32'(err_type), 32'd0);
        check("rst_clk_line", 32'(ps2_clk), 32'd1);
        check("rst_dat_line", 32'(ps2_dat), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) run_vec(vecs[i], 1'b0);

        // Device never clocks: timeout counted from the CLK release.
        pulse_send(8'h12);
        wait_inhibit(low_cnt, dat_idx);
        t = 0;
        while (err == 1'b0 && t < 1000) begin
            t++;
            @(negedge clk);
        end
        check("start_timeout_cycles", 32'(t), 32'(STO));
        check("timeout_err_type", 32'(err_type), 32'd1);
        check("timeout_no_done", 32'(done), 32'd0);
        check("timeout_busy", 32'(busy), 32'd0);
        check("timeout_clk_line", 32'(ps2_clk), 32'd1);
        check("timeout_dat_line", 32'(ps2_dat), 32'd1);
        repeat (5) @(negedge clk);

        // Reset while the device holds the 5th clock low.
        pulse_send(8'h00);
        wait_inhibit(low_cnt, dat_idx);
        repeat (30) @(negedge clk);
        for (int e = 1; e <= 4; e++) dev_edge(e, 1'b1, 1'b0, smp);
        dev_clk_low = 1'b1;
        repeat (6) @(negedge clk);
        check("pre_reset_dat_low", 32'(ps2_dat), 32'd0);
        d0 = done_cnt;
        e0 = err_cnt;
        #2 rst_n = 1'b0;
        #1;
        check("reset_dat_released", 32'(ps2_dat), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_err_type", 32'(err_type), 32'd0);
        dev_clk_low = 1'b0;
        repeat (5) @(negedge clk);
        check("reset_clk_released", 32'(ps2_clk), 32'd1);
        check("reset_no_pulses", 32'((done_cnt - d0) + (err_cnt - e0)), 32'd0);
        // send on the very first cycle after reset release
        rst_n = 1'b1;
        send  = 1'b1;
        cmd   = 8'hF5;
        @(negedge clk);
        send = 1'b0;
        run_vec(v_f5, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
